rvvi_retire_sequencer: RTL and testbench
========================================

Name: rvvi_retire_sequencer

Overview:
- Serialises RVVI retire events from NHART harts × RETIRE slots into a single in-order event stream for the functional-coverage sampler.
- Holds one staged retire group per hart and drains it slot by slot.
- Harts are served round-robin.
- Optionally checks that the `order` count per hart is gap-free.
- Sits between the rvviTrace interface taps and the coverage collectors.

Parameters:
- NHART, 1, number of harts reported
- RETIRE, 1, slots that can retire per hart per cycle
- XLEN, 32, PC width
- ILEN, 32, instruction width
- HW (localparam), NHART>1 ? $clog2(NHART) : 1, hart index width
- SW (localparam), RETIRE>1 ? $clog2(RETIRE) : 1, slot index width

Ports:
- clk  in  1  interface clock
- reset_n  in  1  synchronous active-low reset
- in_valid  in  NHART*RETIRE  per hart/slot retire valid; index h*RETIRE+s
- in_order  in  NHART*RETIRE*64  order count per hart/slot
- in_pc  in  NHART*RETIRE*XLEN  pc_rdata per hart/slot
- in_insn  in  NHART*RETIRE*ILEN  instruction per hart/slot
- in_trap  in  NHART*RETIRE  trap flag per hart/slot
- in_mode  in  NHART*RETIRE*2  privilege mode per hart/slot
- in_ready  out  NHART  hart h staging register empty
- out_valid  out  1  serialised event valid
- out_ready  in  1  consumer accepts event
- out_hart  out  HW  hart of event
- out_slot  out  SW  slot of event
- out_order, out_pc, out_insn, out_trap, out_mode  out  64/XLEN/ILEN/1/2  event fields
- order_err  out  1  sticky order-gap flag
- order_err_hart  out  HW  hart of first order gap

Behaviour:
- Decided: one clock `clk`; reset `reset_n` is synchronous, active-low.
- Reset (reset_n=0 at a clk edge):
  - all stage masks = 0, FSM = IDLE, last_grant = NHART-1 (hart 0 wins first).
  - out_valid = 0, order_err = 0, order_err_hart = 0, in_ready = all 1.
  - All other outputs read 0.
  - Reset mid-drain discards staged events; no partial output follows reset.
- Staging, per hart h:
  - in_ready[h] = (mask[h] == 0).
  - If in_ready[h] and any in_valid bit of hart h is set, the clock edge latches mask[h] = that hart's valid bits and all slot fields.
  - in_valid bits for hart h while in_ready[h] = 0 are ignored. The driver must hold them.
- FSM, states IDLE and DRAIN:
  - IDLE: if any mask nonzero, choose cur = first hart with nonzero mask searching last_grant+1, +2, … (wrap at NHART), then go to DRAIN. Otherwise stay in IDLE.
  - DRAIN: out_valid = 1; out_slot = lowest set bit of mask[cur]; out_* = staged fields of (cur, out_slot).
    - On out_valid && out_ready, clear that bit.
    - If it was the last set bit: last_grant = cur, go to IDLE.
    - out_ready = 0 holds all outputs stable.
- Latency:
  - Group accepted at edge of cycle c → IDLE grant in cycle c+1 → out_valid in cycle c+2.
  - One IDLE bubble between groups.
  - Throughput 1 event/cycle within a group.
- Simultaneous events:
  - The drained hart's in_ready rises the cycle after its last handshake.
  - A new group for that hart may be accepted at that point, but it loses priority to other pending harts.
- Slots are emitted in ascending slot order. Harts are never interleaved within a group.
- Fairness: with all harts continuously pending, each is granted once per NHART groups.

Optional Feature:
- Macro: RVVI_SEQ_ORDER_CHK_EN.
- When defined:
  - Each hart keeps exp_order[h] (64 bit) and seen[h]. Both are cleared by reset.
  - On every output handshake for hart h: if seen[h] && out_order != exp_order[h], set order_err = 1. If this is the first error, latch order_err_hart = h.
  - In all cases on that handshake: exp_order[h] = out_order + 1 (wraps mod 2^64) and seen[h] = 1.
  - order_err clears only on reset.
- When undefined: order_err and order_err_hart are tied to 0; no counters exist.

Decomposition:
- Package rvvi_seq_pkg:
  - seq_state_t enum {IDLE, DRAIN}.
  - ORDER_W = 64, MODE_W = 2.
  - Function lowest_set returning the index of the lowest set bit.
- Staged-record struct is local to the module, since it depends on XLEN/ILEN.
- One sub-module: rvvi_rr_pick (combinational round-robin picker). Inputs: request vector and last_grant. Outputs: grant index and any-request.

Test Plan:
- Single hart, RETIRE=2, in_valid=2'b11, order 5/6 → out_valid in cycle c+2; outputs (slot0, order 5) then (slot1, order 6) in consecutive cycles; in_ready[0] stays 0 until the cycle after the second handshake.
- NHART=3, all harts present one group in the same cycle → output hart order 0, 1, 2; next round of simultaneous groups → 0, 1, 2 again with one IDLE bubble between groups.
- out_ready held 0 for 4 cycles during DRAIN → out_* stable, no mask bit cleared; release → normal drain.
- Sparse mask in_valid=2'b10 → single event with out_slot=1; no slot-0 event.
- RVVI_SEQ_ORDER_CHK_EN, hart 1 emits orders 10, 11, 13 → order_err=1 after the 13 handshake, order_err_hart=1; a later hart-0 gap does not change order_err_hart.
- reset_n=0 for one cycle while in DRAIN with 1 event left → next cycle out_valid=0, in_ready=all 1, order_err=0; no stale event afterward.

Source files
------------

// File: rtl/rvvi_seq_pkg.sv
// rtl/rvvi_seq_pkg.sv - shared types, widths and helpers for the RVVI retire sequencer
package rvvi_seq_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } seq_state_t;

    localparam int ORDER_W = 64;
    localparam int MODE_W  = 2;

    // Returns 0 for an all-zero vector; callers only use it on nonzero masks.
    function automatic int lowest_set(input logic [63:0] vec);
        lowest_set = 0;
        for (int i = 63; i >= 0; i--) begin
            if (vec[i]) begin
                lowest_set = i;
            end
        end
    endfunction

endpackage

// File: rtl/rvvi_rr_pick.sv
// rtl/rvvi_rr_pick.sv - combinational round-robin picker starting after last grant
module rvvi_rr_pick #(
    parameter int N = 1,
    parameter int W = 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic [W-1:0] grant,
    output logic         any
);

    int best;

    // Distance 0 is the hart right after last, so the smallest distance wins.
    always_comb begin
        grant = '0;
        any   = |req;
        best  = N;
        for (int i = 0; i < N; i++) begin
            if (req[i] && (((i + N - 1 - int'(last)) % N) < best)) begin
                best  = (i + N - 1 - int'(last)) % N;
                grant = W'(i);
            end
        end
    end

endmodule

// File: rtl/rvvi_retire_sequencer.sv
// rtl/rvvi_retire_sequencer.sv - serialises per-hart retire groups into one in-order event stream
// Optional order-gap checker: RVVI_SEQ_ORDER_CHK_EN
module rvvi_retire_sequencer
    import rvvi_seq_pkg::*;
#(
    parameter  int NHART  = 1,
    parameter  int RETIRE = 1,
    parameter  int XLEN   = 32,
    parameter  int ILEN   = 32,
    localparam int HW     = (NHART > 1) ? $clog2(NHART) : 1,
    localparam int SW     = (RETIRE > 1) ? $clog2(RETIRE) : 1
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [NHART*RETIRE-1:0]          in_valid,
    input  logic [NHART*RETIRE*ORDER_W-1:0]  in_order,
    input  logic [NHART*RETIRE*XLEN-1:0]     in_pc,
    input  logic [NHART*RETIRE*ILEN-1:0]     in_insn,
    input  logic [NHART*RETIRE-1:0]          in_trap,
    input  logic [NHART*RETIRE*MODE_W-1:0]   in_mode,
    output logic [NHART-1:0]                 in_ready,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [HW-1:0]                    out_hart,
    output logic [SW-1:0]                    out_slot,
    output logic [ORDER_W-1:0]               out_order,
    output logic [XLEN-1:0]                  out_pc,
    output logic [ILEN-1:0]                  out_insn,
    output logic                             out_trap,
    output logic [MODE_W-1:0]                out_mode,
    output logic                             order_err,
    output logic [HW-1:0]                    order_err_hart
);

    typedef struct packed {
        logic [ORDER_W-1:0] order;
        logic [XLEN-1:0]    pc;
        logic [ILEN-1:0]    insn;
        logic               trap;
        logic [MODE_W-1:0]  mode;
    } rec_t;

    seq_state_t        state, next_state;
    logic [HW-1:0]     cur, last_grant, pick;
    logic              pick_any;
    logic [RETIRE-1:0] mask [NHART];
    rec_t              stage [NHART][RETIRE];
    logic [NHART-1:0]  req;
    logic [RETIRE-1:0] cur_mask, slot_bit;
    logic [SW-1:0]     slot;
    rec_t              cur_rec;
    logic              handshake, last_bit;

    always_comb begin
        req      = '0;
        cur_mask = '0;
        for (int h = 0; h < NHART; h++) begin
            req[h] = |mask[h];
            if (cur == HW'(h)) begin
                cur_mask = mask[h];
            end
        end
    end

    assign in_ready = ~req;

    always_comb begin
        slot     = SW'(lowest_set(64'(cur_mask)));
        slot_bit = '0;
        cur_rec  = '0;
        for (int s = 0; s < RETIRE; s++) begin
            slot_bit[s] = (slot == SW'(s));
        end
        for (int h = 0; h < NHART; h++) begin
            for (int s = 0; s < RETIRE; s++) begin
                if (cur == HW'(h) && slot == SW'(s)) begin
                    cur_rec = stage[h][s];
                end
            end
        end
    end

    assign handshake = (state == DRAIN) && out_ready;
    assign last_bit  = (cur_mask & ~slot_bit) == '0;

    rvvi_rr_pick #(
        .N (NHART),
        .W (HW)
    ) u_pick (
        .req   (req),
        .last  (last_grant),
        .grant (pick),
        .any   (pick_any)
    );

    // A hart only loads a new group once its previous group is fully drained.
    always_ff @(posedge clk) begin
        for (int h = 0; h < NHART; h++) begin
            if (!reset_n) begin
                mask[h] <= '0;
            end else if (!req[h] && |in_valid[h*RETIRE +: RETIRE]) begin
                mask[h] <= in_valid[h*RETIRE +: RETIRE];
                for (int s = 0; s < RETIRE; s++) begin
                    stage[h][s].order <= in_order[(h*RETIRE+s)*ORDER_W +: ORDER_W];
                    stage[h][s].pc    <= in_pc[(h*RETIRE+s)*XLEN +: XLEN];
                    stage[h][s].insn  <= in_insn[(h*RETIRE+s)*ILEN +: ILEN];
                    stage[h][s].trap  <= in_trap[h*RETIRE+s];
                    stage[h][s].mode  <= in_mode[(h*RETIRE+s)*MODE_W +: MODE_W];
                end
            end else if (handshake && cur == HW'(h)) begin
                mask[h] <= mask[h] & ~slot_bit;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            cur        <= '0;
            last_grant <= HW'(NHART - 1);
        end else begin
            state <= next_state;
            if (state == IDLE && pick_any) begin
                cur <= pick;
            end
            if (handshake && last_bit) begin
                last_grant <= cur;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (pick_any) next_state = DRAIN;
            DRAIN:   if (handshake && last_bit) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        out_valid = 1'b0;
        out_hart  = '0;
        out_slot  = '0;
        out_order = '0;
        out_pc    = '0;
        out_insn  = '0;
        out_trap  = 1'b0;
        out_mode  = '0;
        if (state == DRAIN) begin
            out_valid = 1'b1;
            out_hart  = cur;
            out_slot  = slot;
            out_order = cur_rec.order;
            out_pc    = cur_rec.pc;
            out_insn  = cur_rec.insn;
            out_trap  = cur_rec.trap;
            out_mode  = cur_rec.mode;
        end
    end

`ifdef RVVI_SEQ_ORDER_CHK_EN
    logic [ORDER_W-1:0] exp_order [NHART];
    logic [NHART-1:0]   seen;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            seen           <= '0;
            order_err      <= 1'b0;
            order_err_hart <= '0;
            for (int h = 0; h < NHART; h++) begin
                exp_order[h] <= '0;
            end
        end else if (handshake) begin
            for (int h = 0; h < NHART; h++) begin
                if (cur == HW'(h)) begin
                    if (seen[h] && out_order != exp_order[h]) begin
                        order_err <= 1'b1;
                        if (!order_err) begin
                            order_err_hart <= cur;
                        end
                    end
                    exp_order[h] <= out_order + 64'd1;
                    seen[h]      <= 1'b1;
                end
            end
        end
    end
`else
    assign order_err      = 1'b0;
    assign order_err_hart = '0;
`endif

endmodule

// File: tb/tb_rvvi_retire_sequencer.sv
// tb/tb_rvvi_retire_sequencer.sv - directed and randomized checks of the retire sequencer
module tb_rvvi_retire_sequencer;

    localparam int NH = 3;
    localparam int RT = 2;
    localparam int XL = 32;
    localparam int IL = 32;

    typedef struct packed {
        logic [1:0]    hart;
        logic [0:0]    slot;
        logic [63:0]   order;
        logic [XL-1:0] pc;
        logic [IL-1:0] insn;
        logic          trap;
        logic [1:0]    mode;
    } ev_t;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [NH*RT-1:0]    in_valid, in_trap;
    logic [NH*RT*64-1:0] in_order;
    logic [NH*RT*XL-1:0] in_pc;
    logic [NH*RT*IL-1:0] in_insn;
    logic [NH*RT*2-1:0]  in_mode;
    logic [NH-1:0]       in_ready;
    logic                out_valid, out_ready;
    logic [1:0]          out_hart;
    logic [0:0]          out_slot;
    logic [63:0]         out_order;
    logic [XL-1:0]       out_pc;
    logic [IL-1:0]       out_insn;
    logic                out_trap;
    logic [1:0]          out_mode;
    logic                order_err;
    logic [1:0]          order_err_hart;

    int          n_pass = 0;
    int          n_total = 0;
    ev_t         expq [NH][$];
    logic [63:0] nxt [NH];
    int          hq [$];
    int          sq [$];
    int          cq [$];
    int          prev_hs_cyc;
    int          prev_hs_hart;

    rvvi_retire_sequencer #(
        .NHART  (NH),
        .RETIRE (RT),
        .XLEN   (XL),
        .ILEN   (IL)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .in_valid       (in_valid),
        .in_order       (in_order),
        .in_pc          (in_pc),
        .in_insn        (in_insn),
        .in_trap        (in_trap),
        .in_mode        (in_mode),
        .in_ready       (in_ready),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_hart       (out_hart),
        .out_slot       (out_slot),
        .out_order      (out_order),
        .out_pc         (out_pc),
        .out_insn       (out_insn),
        .out_trap       (out_trap),
        .out_mode       (out_mode),
        .order_err      (order_err),
        .order_err_hart (order_err_hart)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic put_group(input int h, input logic [RT-1:0] vm);
        ev_t e;
        int  i;
        for (int s = 0; s < RT; s++) begin
            i      = h * RT + s;
            e.hart = 2'(h);
            e.slot = 1'(s);
            e.order = nxt[h];
            e.pc   = $urandom;
            e.insn = $urandom;
            e.trap = 1'($urandom);
            e.mode = 2'($urandom);
            in_valid[i]            = vm[s];
            in_order[i*64 +: 64]   = e.order;
            in_pc[i*XL +: XL]      = e.pc;
            in_insn[i*IL +: IL]    = e.insn;
            in_trap[i]             = e.trap;
            in_mode[i*2 +: 2]      = e.mode;
            if (vm[s]) begin
                expq[h].push_back(e);
                nxt[h] = nxt[h] + 64'd1;
            end
        end
    endtask

    // Each event must be the oldest outstanding one of its hart, in slot order.
    task automatic check_hs(input string tag);
        ev_t e;
        int  hh;
        hh = int'(out_hart);
        if (hh >= NH || expq[hh].size() == 0) begin
            chk({tag, "_unexpected"}, {1'b1, out_hart}, 160'd0);
        end else begin
            e = expq[hh].pop_front();
            chk(tag, {1'b1, out_hart, out_slot, out_order, out_pc, out_insn, out_trap, out_mode},
                {1'b1, e});
        end
    endtask

    task automatic collect(input int n, input int budget, input string tag);
        int got;
        int cyc;
        got = 0;
        cyc = 0;
        hq.delete();
        sq.delete();
        cq.delete();
        while (got < n && cyc < budget) begin
            if (out_valid && out_ready) begin
                hq.push_back(int'(out_hart));
                sq.push_back(int'(out_slot));
                cq.push_back(cyc);
                check_hs(tag);
                got++;
            end
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_count"}, got, n);
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        in_valid  = '0;
        out_ready = 1'b0;
        for (int h = 0; h < NH; h++) begin
            expq[h].delete();
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [159:0] snap;
        int           k;
        int           pend;
        int           vcount;
        logic         exp_err;
        logic [1:0]   exp_err_hart;

        in_valid  = '0;
        in_trap   = '0;
        in_order  = '0;
        in_pc     = '0;
        in_insn   = '0;
        in_mode   = '0;
        out_ready = 1'b0;
        reset_n   = 1'b0;
        for (int h = 0; h < NH; h++) nxt[h] = 64'(h) << 32;
        repeat (2) @(negedge clk);

        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 3'b111);
        chk("rst_fields", {out_hart, out_slot, out_order, out_pc, out_insn, out_trap, out_mode}, 0);
        chk("rst_order_err", {order_err, order_err_hart}, 0);

        // Single group of two slots: latency, back-to-back slots, in_ready timing.
        reset_n   = 1'b1;
        out_ready = 1'b1;
        nxt[0]    = 64'd5;
        put_group(0, 2'b11);
        chk("t1_ready_c", in_ready[0], 1);
        @(negedge clk);
        in_valid = '0;
        chk("t1_valid_c1", out_valid, 0);
        chk("t1_ready_c1", in_ready[0], 0);
        @(negedge clk);
        chk("t1_valid_c2", out_valid, 1);
        chk("t1_order0", {out_slot, out_order}, {1'b0, 64'd5});
        check_hs("t1_ev0");
        @(negedge clk);
        chk("t1_order1", {out_valid, out_slot, out_order}, {1'b1, 1'b1, 64'd6});
        chk("t1_ready_c3", in_ready[0], 0);
        check_hs("t1_ev1");
        @(negedge clk);
        chk("t1_valid_c4", out_valid, 0);
        chk("t1_ready_c4", in_ready[0], 1);

        // All harts at once, two rounds: hart order 0,1,2 with one bubble between groups.
        do_reset();
        out_ready = 1'b1;
        for (int r = 0; r < 2; r++) begin
            for (int h = 0; h < NH; h++) put_group(h, 2'b11);
            @(negedge clk);
            in_valid = '0;
            collect(NH * RT, 40, "t2_ev");
            for (int i = 0; i < hq.size(); i++) begin
                chk("t2_hart_slot", {hq[i], sq[i]}, {i / RT, i % RT});
                if (i > 0) chk("t2_gap", cq[i] - cq[i-1], (i % RT == 0) ? 2 : 1);
            end
        end

        // Consumer stall: outputs and in_ready hold, then normal drain.
        do_reset();
        put_group(1, 2'b11);
        @(negedge clk);
        in_valid = '0;
        k = 0;
        while (!out_valid && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("t3_wait", out_valid, 1);
        snap = {out_valid, out_hart, out_slot, out_order, out_pc, out_insn, out_trap, out_mode};
        repeat (4) begin
            @(negedge clk);
            chk("t3_hold", {out_valid, out_hart, out_slot, out_order, out_pc, out_insn, out_trap, out_mode}, snap);
        end
        chk("t3_ready_hold", in_ready[1], 0);
        out_ready = 1'b1;
        collect(2, 10, "t3_ev");
        chk("t3_slots", {sq[0], sq[1]}, {32'd0, 32'd1});

        // Sparse group: only slot 1 valid.
        put_group(2, 2'b10);
        @(negedge clk);
        in_valid = '0;
        collect(1, 10, "t4_ev");
        chk("t4_slot", sq[0], 1);
        vcount = 0;
        repeat (3) begin
            @(negedge clk);
            if (out_valid) vcount++;
        end
        chk("t4_no_extra", {vcount, expq[2].size()}, 0);

        // Order gap on hart 1 (10,11,13), later gap on hart 0.
        do_reset();
        out_ready = 1'b1;
        nxt[1] = 64'd10;
        put_group(1, 2'b11);
        @(negedge clk);
        in_valid = '0;
        collect(2, 10, "t5_a");
        nxt[1] = 64'd13;
        put_group(1, 2'b01);
        @(negedge clk);
        in_valid = '0;
        collect(1, 10, "t5_b");
`ifdef RVVI_SEQ_ORDER_CHK_EN
        exp_err      = 1'b1;
        exp_err_hart = 2'd1;
`else
        exp_err      = 1'b0;
        exp_err_hart = 2'd0;
`endif
        chk("t5_err_h1", {order_err, order_err_hart}, {exp_err, exp_err_hart});
        nxt[0] = 64'd100;
        put_group(0, 2'b01);
        @(negedge clk);
        in_valid = '0;
        collect(1, 10, "t5_c");
        nxt[0] = 64'd200;
        put_group(0, 2'b01);
        @(negedge clk);
        in_valid = '0;
        collect(1, 10, "t5_d");
        chk("t5_err_keep", {order_err, order_err_hart}, {exp_err, exp_err_hart});

        // Reset with one event still staged.
        put_group(0, 2'b11);
        @(negedge clk);
        in_valid = '0;
        k = 0;
        while (!out_valid && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("t6_wait", out_valid, 1);
        check_hs("t6_ev0");
        @(negedge clk);
        chk("t6_pending", {out_valid, out_slot}, 2'b11);
        reset_n = 1'b0;
        @(negedge clk);
        chk("t6_after_rst", {out_valid, in_ready, order_err, out_order}, {1'b0, 3'b111, 1'b0, 64'd0});
        reset_n = 1'b1;
        for (int h = 0; h < NH; h++) expq[h].delete();
        vcount = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) vcount++;
        end
        chk("t6_no_stale", vcount, 0);

        // Randomized traffic against per-hart expected queues.
        do_reset();
        prev_hs_cyc  = -10;
        prev_hs_hart = -1;
        for (int c = 0; c < 600; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            for (int h = 0; h < NH; h++) begin
                if (in_ready[h] && $urandom_range(0, 2) == 0) put_group(h, 2'($urandom_range(1, 3)));
                else put_group(h, 2'b00);
            end
            if (out_valid && out_ready) begin
                if (prev_hs_cyc == c - 1) chk("rnd_no_interleave", out_hart, prev_hs_hart);
                prev_hs_cyc  = c;
                prev_hs_hart = int'(out_hart);
                check_hs("rnd_ev");
            end
            @(negedge clk);
        end
        in_valid  = '0;
        out_ready = 1'b1;
        k = 0;
        pend = 1;
        while (pend > 0 && k < 300) begin
            if (out_valid) check_hs("rnd_drain_ev");
            @(negedge clk);
            k++;
            pend = 0;
            for (int h = 0; h < NH; h++) pend += expq[h].size();
        end
        chk("rnd_drained", pend, 0);
        repeat (2) @(negedge clk);
        chk("rnd_idle", {out_valid, in_ready}, {1'b0, 3'b111});
        chk("rnd_no_order_err", order_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
